// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding for the convolution start sequencer.
package conv_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR_ST   = 3'd1,
    START_ST = 3'd2,
    RUN_ST   = 3'd3,
    FIN      = 3'd4,
    HOLD     = 3'd5
  } start_seq_state_t;
endpackage

// File: rtl/conv_start_seq_cycle_cnt.sv
// cycle_cnt: loadable down-counter with a zero flag.
module cycle_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst ? '0 : load ? load_val : (dec && cnt != '0) ? cnt - 1'b1 : cnt;
  assign zero = cnt == '0;
endmodule

// File: rtl/conv_start_seq.sv
// conv_start_seq: CLR/start sequencer over N_CH channels and num_runs passes.
// Optional done watchdog enabled by defining CONV_START_SEQ_TIMEOUT_EN.
module conv_start_seq
  import conv_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int CLR_CYCLES     = 1,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CHW           = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [CNT_W-1:0] num_runs,
  input  logic [N_CH-1:0]  done,
  output logic             CLR,
  output logic [N_CH-1:0]  start,
  output logic [CHW-1:0]   ch_idx,
  output logic [CNT_W-1:0] run_idx,
  output logic             busy,
  output logic             finished,
  output logic             timeout
);
  localparam int CW = CLR_CYCLES > 1 ? $clog2(CLR_CYCLES) : 1;
  start_seq_state_t state, state_n;
  logic [CHW-1:0] ch_q, ch_n;
  logic [CNT_W-1:0] run_q, run_n, runs_q, runs_n;
  logic clr_zero, done_act, last_ch, last_run, wd_exp;
  if (N_CH < 1 || CLR_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("conv_start_seq: N_CH, CLR_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end
  // Counter reloads whenever CLR_ST is not active, so every entry starts a fresh pulse.
  cycle_cnt #(.W(CW)) u_clr (
    .clk(clk), .rst(rst), .load(state != CLR_ST), .dec(state == CLR_ST),
    .load_val(CW'(CLR_CYCLES - 1)), .zero(clr_zero)
  );
`ifdef CONV_START_SEQ_TIMEOUT_EN
  localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic wd_zero, to_q;
  cycle_cnt #(.W(WW)) u_wd (
    .clk(clk), .rst(rst), .load(state != RUN_ST), .dec(state == RUN_ST),
    .load_val(WW'(TIMEOUT_CYCLES - 1)), .zero(wd_zero)
  );
  assign wd_exp = wd_zero;
  always_ff @(posedge clk)
    if (rst) to_q <= 1'b0;
    else if (state == IDLE && En) to_q <= 1'b0;
    else if (state == RUN_ST && En && !done_act && wd_zero) to_q <= 1'b1;
  assign timeout = to_q;
`else
  assign wd_exp  = 1'b0;
  assign timeout = 1'b0;
`endif
  assign done_act = |(done & (N_CH'(1) << ch_q));
  assign last_ch  = ch_q == CHW'(N_CH - 1);
  assign last_run = run_q == runs_q - 1'b1;
  always_comb begin
    state_n = state;
    ch_n    = ch_q;
    run_n   = run_q;
    runs_n  = runs_q;
    case (state)
      IDLE: if (En) begin
        state_n = CLR_ST;
        runs_n  = num_runs == '0 ? CNT_W'(1) : num_runs;
      end
      CLR_ST:   state_n = !En ? IDLE : clr_zero ? START_ST : CLR_ST;
      START_ST: state_n = En ? RUN_ST : IDLE;
      RUN_ST:
        if (!En) state_n = IDLE;
        else if (done_act) begin
          if (!last_ch) begin
            ch_n    = ch_q + 1'b1;
            state_n = CLR_ST;
          end else if (!last_run) begin
            ch_n    = '0;
            run_n   = run_q + 1'b1;
            state_n = CLR_ST;
          end else state_n = FIN;
        end else if (wd_exp) state_n = HOLD;
      FIN:     state_n = HOLD;
      HOLD:    state_n = En ? HOLD : IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) begin
      ch_n  = '0;
      run_n = '0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      ch_q   <= '0;
      run_q  <= '0;
      runs_q <= '0;
    end else begin
      state  <= state_n;
      ch_q   <= ch_n;
      run_q  <= run_n;
      runs_q <= runs_n;
    end
  assign busy     = state inside {CLR_ST, START_ST, RUN_ST};
  assign CLR      = state == CLR_ST;
  assign start    = state == START_ST ? N_CH'(1) << ch_q : '0;
  assign ch_idx   = busy ? ch_q : '0;
  assign run_idx  = busy ? run_q : '0;
  assign finished = state == FIN;
endmodule

// File: tb/tb_conv_start_seq.sv
// tb_conv_start_seq: scoreboard bench, N_CH=4, CLR_CYCLES=3, TIMEOUT_CYCLES=16.
module tb_conv_start_seq;
  localparam int N = 4, C = 3, T = 16;
  logic clk = 0, rst = 1, En = 0;
  logic [7:0] num_runs = 0;
  logic [N-1:0] done = 0;
  logic CLR, busy, finished, timeout;
  logic [N-1:0] start;
  logic [1:0] ch_idx;
  logic [7:0] run_idx;
  typedef struct {
    bit fin;
    logic [N-1:0] start;
    logic [1:0] ch;
    logic [7:0] run;
  } ev_t;
  ev_t q[$];
  ev_t mon_e;
  int tests = 0, fails = 0, clr_cnt = 0;
  always #5 clk = ~clk;
  conv_start_seq #(.N_CH(N), .CLR_CYCLES(C), .CNT_W(8), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .En(En), .num_runs(num_runs), .done(done), .CLR(CLR),
    .start(start), .ch_idx(ch_idx), .run_idx(run_idx), .busy(busy),
    .finished(finished), .timeout(timeout)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic exp_start(input int ch, input int run);
    ev_t e;
    e.fin = 0; e.start = N'(1) << ch; e.ch = 2'(ch); e.run = 8'(run);
    q.push_back(e);
  endtask
  task automatic exp_fin();
    ev_t e;
    e.fin = 1; e.start = '0; e.ch = '0; e.run = '0;
    q.push_back(e);
  endtask
  // Monitor: pops one expected event for every start or finished pulse.
  always @(negedge clk)
    if (rst) clr_cnt <= 0;
    else begin
      if (start != '0 || finished) begin
        if (q.size() == 0) chk("unexpected_output", {start, finished}, 0);
        else begin
          mon_e = q.pop_front();
          chk("event_kind", finished, mon_e.fin);
          if (!mon_e.fin) begin
            chk("start_vec", start, mon_e.start);
            chk("ch_idx", ch_idx, mon_e.ch);
            chk("run_idx", run_idx, mon_e.run);
            chk("clr_len", clr_cnt, C);
          end
        end
      end
      clr_cnt <= CLR ? clr_cnt + 1 : 0;
    end
  task automatic wait_start(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (start == '0 && n < 40);
    chk("start_seen", start != '0, 1);
  endtask
  task automatic wait_fin(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!finished && n < 40);
    chk("fin_seen", finished, 1);
  endtask
  task automatic run_seq(input logic [7:0] nr, input int dly, input int noisy_ch);
    int passes = nr == 0 ? 1 : int'(nr);
    int n;
    bit last;
    num_runs = nr; En = 1; exp_start(0, 0);
    @(posedge clk); #1;
    for (int p = 0; p < passes; p++)
      for (int c = 0; c < N; c++) begin
        wait_start(n);
        chk("start_lat", n, C + 1);
        if (c == noisy_ch) begin
          done = N'(1) << c;
          @(posedge clk); #1;
          done = ~(N'(1) << c);
          repeat (2) begin @(negedge clk); chk("done_ignored", {busy, CLR}, 2'b10); end
          @(posedge clk); #1;
          done = '0;
        end else begin
          @(posedge clk); #1;
        end
        repeat (dly) begin @(posedge clk); #1; end
        last = p == passes - 1 && c == N - 1;
        if (last) exp_fin();
        else exp_start(c == N - 1 ? 0 : c + 1, c == N - 1 ? p + 1 : p);
        done = N'(1) << c;
        @(posedge clk); #1;
        done = '0;
        if (last) begin wait_fin(n); chk("fin_lat", n, 1); end
      end
    repeat (3) begin @(negedge clk); chk("hold_quiet", {CLR, start, busy, finished}, 0); end
    @(posedge clk); #1; En = 0;
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {CLR, start, ch_idx, run_idx, busy, finished, timeout}, 0);
    rst = 0;
    @(posedge clk); #1;
    run_seq(8'd2, 2, 2);
    run_seq(8'd0, 0, -1);
    num_runs = 1; En = 1;
    @(posedge clk); #1;
    En = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_clr", {busy, CLR, start}, 0);
    @(posedge clk); #1;
    En = 1; exp_start(0, 0);
    @(posedge clk); #1;
    wait_start(n);
    @(posedge clk); #1;
    exp_start(1, 0);
    done = 4'b0001;
    @(posedge clk); #1;
    done = '0;
    wait_start(n);
    @(posedge clk); #1;
    En = 0;
    @(posedge clk); #1;
    chk("abort_run", {busy, CLR, start, ch_idx, run_idx, finished}, 0);
    run_seq(8'd1, 1, -1);
    En = 1; num_runs = 3; exp_start(0, 0);
    @(posedge clk); #1;
    wait_start(n);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_run", {CLR, start, ch_idx, run_idx, busy, finished, timeout}, 0);
    rst = 0; En = 0;
    @(posedge clk); #1;
`ifdef CONV_START_SEQ_TIMEOUT_EN
    num_runs = 1; En = 1; exp_start(0, 0);
    @(posedge clk); #1;
    wait_start(n);
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout && n < 40);
    chk("wd_lat", n, T + 1);
    chk("wd_hold", {busy, finished, timeout}, 3'b001);
    @(posedge clk); #1; En = 0;
    @(posedge clk); #1;
    chk("wd_sticky_idle", timeout, 1);
    run_seq(8'd1, 0, -1);
    chk("wd_cleared", timeout, 0);
`endif
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv_start_seq.md
# conv_start_seq

Parametrised start sequencer for the convolution engine: on `En` it issues a multi-cycle `CLR` pulse, then a one-cycle `start` to one channel, waits for that channel's `done`, and repeats across `N_CH` channels and `num_runs` passes. It then reports completion and holds until `En` is released. It sits between the host/control register block and the per-channel MAC arrays. It replaces the fixed one-cycle clear/start sequence with configurable clear length, channel sequencing, pass counting, abort and optional watchdog.

## Interface
Parameters:
- `N_CH`, 4: number of engine channels (≥1).
- `CLR_CYCLES`, 1: `CLR` pulse length in cycles (≥1).
- `CNT_W`, 8: width of `num_runs` and `run_idx`.
- `TIMEOUT_CYCLES`, 1024: `done` watchdog limit; used only when the watchdog macro is defined.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `En` in 1: level enable/arm; deassertion aborts.
- `num_runs` in `CNT_W`: passes over all channels; sampled in IDLE when `En` rises; 0 is treated as 1.
- `done` in `N_CH`: per-channel completion, level or pulse; only the active channel's bit is observed.
- `CLR` out 1: accumulator clear.
- `start` out `N_CH`: one-hot, one-cycle start to the active channel.
- `ch_idx` out max(1,$clog2(`N_CH`)): active channel.
- `run_idx` out `CNT_W`: current pass, 0-based.
- `busy` out 1: high in CLR_ST, START_ST and RUN_ST.
- `finished` out 1: one-cycle pulse after the last `done`.
- `timeout` out 1: sticky watchdog flag; tied 0 when the watchdog is compiled out.

## Operation
States are IDLE, CLR_ST, START_ST, RUN_ST, FIN, HOLD.
- IDLE: all outputs 0. If `En`=1: latch `num_runs` (0→1), set `ch_idx`=0 and `run_idx`=0, go to CLR_ST.
- CLR_ST: `CLR`=1 for exactly `CLR_CYCLES` cycles, counted by a cycle counter, then go to START_ST.
- START_ST: `start[ch_idx]`=1 for one cycle, then go to RUN_ST. `done` is ignored in this state.
- RUN_ST: wait for `done[ch_idx]`=1.
  - If this is not the last channel: `ch_idx`+1, go to CLR_ST.
  - If it is the last channel but not the last run: `ch_idx`=0, `run_idx`+1, go to CLR_ST.
  - Otherwise go to FIN.
- FIN: `finished`=1 for one cycle, go to HOLD.
- HOLD: all outputs 0 (`timeout` keeps its value). Stay while `En`=1; `En`=0 → IDLE. A new run needs an `En` low→high cycle.
- Abort: `En`=0 in CLR_ST, START_ST or RUN_ST → IDLE on the next edge. Counters are cleared and no `finished` pulse is issued.
- Priority when events coincide: `rst` > abort (`En`=0) > `done`/counter expiry.
- `rst` in any state → IDLE, all outputs and counters 0, `timeout` cleared.
- Unused state encodings → IDLE.

## Timing
- Outputs are Moore, decoded from registered state and counters. There is no combinational path from inputs to outputs.
- `En` high at edge k → `CLR` high in cycles k+1 … k+`CLR_CYCLES`, `start` high in cycle k+`CLR_CYCLES`+1.
- `done[ch_idx]` seen at edge m in RUN_ST → next `CLR` in cycle m+1, or `finished` in cycle m+1.
- Minimum period per channel: `CLR_CYCLES`+2 cycles, reached when `done` arrives on the first RUN_ST cycle.
- `run_idx` wraps are impossible because the run count is bounded by the latched `num_runs`.

## Configuration
- `CONV_START_SEQ_TIMEOUT_EN` defined: a counter runs in RUN_ST and resets on state entry. When it reaches `TIMEOUT_CYCLES` without `done`: set `timeout`=1 (sticky until `rst` or the next IDLE→CLR_ST transition), go to HOLD, no `finished` pulse.
- Macro not defined: RUN_ST waits indefinitely, `timeout` is tied 0, and no watchdog counter is synthesised.

## Structure
- Shared `conv_pkg`: state enum typedef `start_seq_state_t` and its encodings.
- One sub-module: `cycle_cnt`, a loadable down-counter with a zero flag. It is instantiated for the CLR length and for the watchdog, which is generated only under the macro.

## Test plan
- `N_CH`=1, `CLR_CYCLES`=1, `num_runs`=1, `done` 3 cycles after `start` → `CLR` 1 cycle, `start` 1 cycle, `finished` 1 cycle later; HOLD until `En`=0.
- `N_CH`=4, `CLR_CYCLES`=3, `num_runs`=2 → 8 `start` pulses on ch 0,1,2,3,0,1,2,3, each preceded by 3 `CLR` cycles; `run_idx` 0 then 1; one `finished`.
- `num_runs`=0 → behaves exactly like `num_runs`=1.
- `En` dropped during CLR_ST and again during RUN_ST → IDLE next cycle, no `finished`; re-raising `En` restarts at ch 0, run 0.
- `done` asserted on a non-active channel and during START_ST → ignored; `rst` mid-RUN_ST → all outputs 0 next cycle.
- Macro defined, `TIMEOUT_CYCLES`=16, `done` never asserted → `timeout`=1 after 16 RUN_ST cycles, state HOLD, `finished` stays 0.
